stopwatch_core: RTL

Parametrised run/stop/clear stopwatch core that generalises the fixed 100 Hz, 0–9999 up-counter.
- Configurable clock and tick rates, configurable modulus, up/down counting mode.
- Internal button edge detection, wrap flag, optional lap-hold display latch.
- Feeds the FND controller via o_count; sits between the debounced button inputs and the display path.

---
 rtl/stopwatch_core.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - run/stop/clear stopwatch with prescaler, up/down wrap counter
// Optional lap-hold display latch enabled by STOPWATCH_LAP_HOLD_EN.
module stopwatch_core #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MAX_COUNT = 9999,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run_stop,
    input  logic             i_clear,
    input  logic             i_mode,
    input  logic             i_lap,
    output logic [CNT_W-1:0] o_count,
    output logic             o_running,
    output logic             o_tick,
    output logic             o_wrap
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = $clog2(DIV);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t           state_q;
    logic [PS_W-1:0]  ps_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             run_prev_q;
    logic             clr_prev_q;
    logic             run_edge;
    logic             clr_edge;
    logic             tick;
    logic             wrap_cond;

    assign run_edge  = i_run_stop & ~run_prev_q;
    assign clr_edge  = i_clear & ~clr_prev_q;
    assign tick      = (state_q == ST_RUN) && (ps_q == PS_LAST);
    assign wrap_cond = i_mode ? (count_q == '0) : (count_q == CNT_MAX);

    always_comb begin
        count_d = count_q;
        if (wrap_cond) begin
            count_d = i_mode ? CNT_MAX : '0;
        end else if (i_mode) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // run_stop has priority over clear when both edges land in STOP together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_STOP;
            ps_q       <= '0;
            count_q    <= '0;
            run_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            run_prev_q <= i_run_stop;
            clr_prev_q <= i_clear;
            case (state_q)
                ST_STOP: begin
                    if (run_edge) begin
                        state_q <= ST_RUN;
                    end else if (clr_edge) begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_RUN: begin
                    if (run_edge) begin
                        state_q <= ST_STOP;
                    end
                    if (tick) begin
                        ps_q    <= '0;
                        count_q <= count_d;
                    end else begin
                        ps_q <= ps_q + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    ps_q    <= '0;
                    count_q <= '0;
                    state_q <= ST_STOP;
                end
                default: begin
                    state_q <= ST_STOP;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic             lap_prev_q;
    logic             hold_q;
    logic [CNT_W-1:0] lap_q;
    logic             lap_edge;

    assign lap_edge = i_lap & ~lap_prev_q;

    // Lap toggles the display freeze only while running; an existing hold survives STOP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_prev_q <= 1'b0;
            hold_q     <= 1'b0;
            lap_q      <= '0;
        end else begin
            lap_prev_q <= i_lap;
            if (state_q == ST_CLEAR) begin
                hold_q <= 1'b0;
            end else if ((state_q == ST_RUN) && lap_edge) begin
                if (!hold_q) begin
                    lap_q  <= count_q;
                    hold_q <= 1'b1;
                end else begin
                    hold_q <= 1'b0;
                end
            end
        end
    end

    assign o_count = hold_q ? lap_q : count_q;
`else
    logic unused_lap;
    assign unused_lap = i_lap;
    assign o_count    = count_q;
`endif

    assign o_running = (state_q == ST_RUN);
    assign o_tick    = tick;
    assign o_wrap    = tick && wrap_cond;

endmodule
